// File: rtl/prn_chip_sequencer_if.sv
// Seed configuration channel for the PRN chip sequencer.
// The channel controller drives the master side; the sequencer is the slave.
interface prn_chip_sequencer_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [0:9] cfg_r0;
    logic [0:9] cfg_r1;

    modport master (output cfg_valid, output cfg_r0, output cfg_r1, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_r0, input cfg_r1, output cfg_ready);
endinterface

// File: rtl/prn_chip_sequencer.sv
// NavIC L1 PRN chip sequencer: holds the R0/R1 seed pair, steps one chip per
// chip_tick while running, and reloads the seeds with an epoch strobe every
// CODE_LEN chips. Register bit 0 is the MSB and the next bit shifted out.
module prn_chip_sequencer #(
    parameter int CODE_LEN = 1800,
    parameter int IDX_W    = 11,
    parameter int EPOCH_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prn_chip_sequencer_if.slave   cfg,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  chip_tick,
    output logic                  chip_out,
    output logic                  chip_valid,
    output logic [IDX_W-1:0]      chip_idx,
    output logic                  epoch,
    output logic [EPOCH_W-1:0]    epoch_cnt,
    output logic                  busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [0:9]           r_seed0;
    logic [0:9]           r_seed1;
    logic [0:9]           r_w0;
    logic [0:9]           r_w1;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_seeded;
    logic                 r_chip_out;
    logic                 r_chip_valid;
    logic [IDX_W-1:0]     r_chip_idx;
    logic                 r_epoch;
    logic [EPOCH_W-1:0]   r_epoch_cnt;
    logic                 r_busy;

    logic                 w_cfg_ready;
    logic                 w_hs;

    // R0 register advance: plain 4-tap linear feedback into bit 9.
    function automatic logic [0:9] step_w0(input logic [0:9] w0);
        return {w0[1:9], w0[5] ^ w0[2] ^ w0[1] ^ w0[0]};
    endfunction

    // R1 register advance: nonlinear term s2 from R0 plus linear taps of both registers.
    function automatic logic [0:9] step_w1(input logic [0:9] w0, input logic [0:9] w1);
        logic s2;
        logic t;
        logic fb;
        s2 = ((w0[5] ^ w0[2]) & (w0[1] ^ w0[0])) ^ ((w0[5] & w0[2]) ^ (w0[1] & w0[0]));
        t  = w0[6] ^ w0[3] ^ w0[2] ^ w0[0];
        fb = s2 ^ t ^ w1[5] ^ w1[2] ^ w1[1] ^ w1[0];
        return {w1[1:9], fb};
    endfunction

    // Seeds are only accepted while idle so a running code is never disturbed.
    assign w_cfg_ready   = (r_state == S_IDLE);
    assign w_hs          = cfg.cfg_valid && w_cfg_ready;
    assign cfg.cfg_ready = w_cfg_ready;

    assign chip_out   = r_chip_out;
    assign chip_valid = r_chip_valid;
    assign chip_idx   = r_chip_idx;
    assign epoch      = r_epoch;
    assign epoch_cnt  = r_epoch_cnt;
    assign busy       = r_busy;

    // Run-state FSM with seed capture, chip stepping, period wrap and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_seed0      <= '0;
            r_seed1      <= '0;
            r_w0         <= '0;
            r_w1         <= '0;
            r_idx        <= '0;
            r_seeded     <= 1'b0;
            r_chip_out   <= 1'b0;
            r_chip_valid <= 1'b0;
            r_chip_idx   <= '0;
            r_epoch      <= 1'b0;
            r_epoch_cnt  <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_chip_valid <= 1'b0;
                    r_epoch      <= 1'b0;
                    if (w_hs) begin
                        r_seed0  <= cfg.cfg_r0;
                        r_seed1  <= cfg.cfg_r1;
                        r_w0     <= cfg.cfg_r0;
                        r_w1     <= cfg.cfg_r1;
                        r_idx    <= '0;
                        r_seeded <= 1'b1;
                    end
                    // A seed accepted in this same clock counts as seeded.
                    if (start && (r_seeded || w_hs) && !stop) begin
                        r_state     <= S_RUN;
                        r_busy      <= 1'b1;
                        r_epoch_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        // Abort: rewind to the start of the code, drop any coincident tick.
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_chip_valid <= 1'b0;
                        r_epoch      <= 1'b0;
                        r_w0         <= r_seed0;
                        r_w1         <= r_seed1;
                        r_idx        <= '0;
                    end else if (chip_tick) begin
                        r_chip_out   <= r_w1[0];
                        r_chip_idx   <= r_idx;
                        r_chip_valid <= 1'b1;
                        if (r_idx == LAST_IDX) begin
                            // Period boundary: reload instead of stepping.
                            r_epoch     <= 1'b1;
                            r_w0        <= r_seed0;
                            r_w1        <= r_seed1;
                            r_idx       <= '0;
                            r_epoch_cnt <= r_epoch_cnt + EPOCH_W'(1);
                        end else begin
                            r_epoch <= 1'b0;
                            r_w0    <= step_w0(r_w0);
                            r_w1    <= step_w1(r_w0, r_w1);
                            r_idx   <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_chip_valid <= 1'b0;
                        r_epoch      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
